// File: rtl/wb_collector.sv
// Write-back collector: gathers results from NUM_SRC execution lanes into per-lane FIFOs and
// issues at most one write-back per cycle to the bypass buffer / register file.
//
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   I_Stall           no issue while high
//   I_Full            downstream bypass buffer full; no issue while high
//   I_Res_Index[i]    lane i result destination, MSB is the valid bit
//   I_Res_Data[i]     lane i result data
//   O_Busy[i]         lane i FIFO full; lane must not present a result
//   O_WB_Index        registered write-back index, MSB is a one-cycle store strobe
//   O_WB_Data         write-back data, qualified by the O_WB_Index strobe
//   O_Empty           all FIFOs empty and no strobe pending
//   O_Overflow        sticky: a result was dropped at a full lane
module wb_collector #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned IDX_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 I_Stall,
  input  logic                                 I_Full,
  input  logic [NUM_SRC-1:0][IDX_WIDTH:0]      I_Res_Index,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   I_Res_Data,
  output logic [NUM_SRC-1:0]                   O_Busy,
  output logic [IDX_WIDTH:0]                   O_WB_Index,
  output logic [DATA_WIDTH-1:0]                O_WB_Data,
  output logic                                 O_Empty,
  output logic                                 O_Overflow
);

  localparam int unsigned PtrW  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned LaneW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [IDX_WIDTH-1:0]  mem_idx_q  [NUM_SRC][QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [NUM_SRC][QUEUE_DEPTH];
  logic [PtrW-1:0]       wr_q       [NUM_SRC];
  logic [PtrW-1:0]       rd_q       [NUM_SRC];
  logic [CntW-1:0]       cnt_q      [NUM_SRC];
  logic [LaneW-1:0]      rr_q, rr_d;
  logic                  wb_v_q;
  logic [IDX_WIDTH-1:0]  wb_idx_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic                  ovf_q;

  logic [NUM_SRC-1:0]    valid, busy, push, pop, nonempty;
  logic                  iss;
  logic                  win_found;
  logic [LaneW-1:0]      win_lane;
  int unsigned           scan_lane;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      valid[i]    = I_Res_Index[i][IDX_WIDTH];
      busy[i]     = (cnt_q[i] == CntW'(QUEUE_DEPTH));
      nonempty[i] = (cnt_q[i] != '0);
      // Busy uses the pre-edge count, so a full lane rejects a push even if it pops this edge.
      push[i]     = valid[i] & ~busy[i];
    end
  end

  assign iss = ~I_Stall & ~I_Full & (|nonempty);

  // Round-robin scan starting at the RR pointer; first non-empty lane wins.
  always_comb begin
    win_found = 1'b0;
    win_lane  = '0;
    scan_lane = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scan_lane = (32'(rr_q) + k) % NUM_SRC;
      if (!win_found && nonempty[scan_lane]) begin
        win_found = 1'b1;
        win_lane  = LaneW'(scan_lane);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pop[i] = iss & (32'(win_lane) == i);
    end
    rr_d = rr_q;
    if (iss) begin
      rr_d = (32'(win_lane) == NUM_SRC - 1) ? '0 : win_lane + LaneW'(1);
    end
  end

  // Storage needs no reset: occupancy is tracked by the counts alone.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem_idx_q[i][wr_q[i]]  <= I_Res_Index[i][IDX_WIDTH-1:0];
        mem_data_q[i][wr_q[i]] <= I_Res_Data[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      rr_q      <= '0;
      wb_v_q    <= 1'b0;
      wb_idx_q  <= '0;
      wb_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + PtrW'(1);
        if (pop[i])  rd_q[i] <= rd_q[i] + PtrW'(1);
        cnt_q[i] <= cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      end
      rr_q   <= rr_d;
      wb_v_q <= iss;
      if (iss) begin
        wb_idx_q  <= mem_idx_q[win_lane][rd_q[win_lane]];
        wb_data_q <= mem_data_q[win_lane][rd_q[win_lane]];
      end
      ovf_q <= ovf_q | (|(valid & busy));
    end
  end

  assign O_Busy     = busy;
  assign O_WB_Index = {wb_v_q, wb_idx_q};
  assign O_WB_Data  = wb_data_q;
  assign O_Empty    = ~(|nonempty) & ~wb_v_q;
  assign O_Overflow = ovf_q;

endmodule
